// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//   32-bit down-counting timer engine behind the Picoblaze timer register
//   block. A free-running prescaler divides the clock into count ticks; on
//   each tick the counter decrements, and when it is already zero the tick is
//   an expiry: a one-clock timer_expired pulse, the sticky timer_interrupt is
//   set (unless timer_interrupt_clear holds it low) and the counter reloads
//   from timer_count.
//
//   Optional feature macro: TIMER_COUNTER_ONESHOT_EN
//     Defined   : an expiry parks the engine in DONE with the counter at 0;
//                 timer_enable must go low (back to IDLE) to re-arm.
//     Undefined : periodic auto-reload (IDLE and RUN states only).
// ---------------------------------------------------------------------------
module timer_counter #(
    parameter int PRESCALE_DIV   = 1,   // clocks per count tick, >= 1
    parameter int PRESCALE_WIDTH = 16   // PRESCALE_DIV < 2**PRESCALE_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_enable,
    input  logic [31:0] timer_count,
    input  logic        timer_interrupt_clear,
    output logic        timer_interrupt,
    output logic        timer_expired,
    output logic [31:0] timer_current,
    output logic        timer_running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef TIMER_COUNTER_ONESHOT_EN
        ,
        ST_DONE = 2'd2
`endif
    } state_e;

    // Prescaler value on which a tick is issued.
    localparam logic [PRESCALE_WIDTH-1:0] TICK_AT = PRESCALE_WIDTH'(PRESCALE_DIV - 1);

    state_e                    state_q,     state_d;
    logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [31:0]               current_q,   current_d;
    logic                      interrupt_q, interrupt_d;
    logic                      expired_q,   expired_d;
    logic                      running_q,   running_d;

    logic tick;
    logic expiry;

    assign tick = (prescaler_q == TICK_AT);

    // Next-state logic: FSM, prescaler, counter and the derived outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned -- otherwise synthesis infers a latch.
        state_d     = state_q;
        prescaler_d = prescaler_q;
        current_d   = current_q;
        expiry      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                prescaler_d = '0;
                if (timer_enable) begin
                    current_d = timer_count;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!timer_enable) begin
                    // Disable wins over a coincident tick: counter freezes.
                    state_d     = ST_IDLE;
                    prescaler_d = '0;
                end else if (tick) begin
                    prescaler_d = '0;
                    if (current_q != 32'd0) begin
                        current_d = current_q - 32'd1;
                    end else begin
                        expiry = 1'b1;
`ifdef TIMER_COUNTER_ONESHOT_EN
                        state_d   = ST_DONE;
                        current_d = 32'd0;
`else
                        // Reload uses the value present on this clock, so
                        // mid-count writes only take effect here.
                        current_d = timer_count;
`endif
                    end
                end else begin
                    prescaler_d = prescaler_q + PRESCALE_WIDTH'(1);
                end
            end

`ifdef TIMER_COUNTER_ONESHOT_EN
            ST_DONE: begin
                prescaler_d = '0;
                if (!timer_enable) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d     = ST_IDLE;
                prescaler_d = '0;
            end
        endcase

        // Clear has priority over a coincident expiry.
        expired_d   = expiry;
        interrupt_d = timer_interrupt_clear ? 1'b0 : (interrupt_q | expiry);
        running_d   = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q     <= ST_IDLE;
            prescaler_q <= '0;
            current_q   <= 32'd0;
            interrupt_q <= 1'b0;
            expired_q   <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            current_q   <= current_d;
            interrupt_q <= interrupt_d;
            expired_q   <= expired_d;
            running_q   <= running_d;
        end
    end

    assign timer_interrupt = interrupt_q;
    assign timer_expired   = expired_q;
    assign timer_current   = current_q;
    assign timer_running   = running_q;

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
//   Two instances share the stimulus: one with PRESCALE_DIV=1, one with
//   PRESCALE_DIV=4. A reference model computes the expected outputs from the
//   elapsed time since the last load: with ticks every DIV clocks, tick k of
//   a period shows N-k, and tick N+1 is the expiry.
// ---------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] cnt = 32'd0;
    logic        clr = 1'b0;

    logic        intr_a, exp_a, run_a;
    logic [31:0] cur_a;
    logic        intr_b, exp_b, run_b;
    logic [31:0] cur_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    timer_counter #(.PRESCALE_DIV(1), .PRESCALE_WIDTH(16)) u_dut_div1 (
        .clk                   (clk),
        .reset                 (reset),
        .timer_enable          (en),
        .timer_count           (cnt),
        .timer_interrupt_clear (clr),
        .timer_interrupt       (intr_a),
        .timer_expired         (exp_a),
        .timer_current         (cur_a),
        .timer_running         (run_a)
    );

    timer_counter #(.PRESCALE_DIV(4), .PRESCALE_WIDTH(16)) u_dut_div4 (
        .clk                   (clk),
        .reset                 (reset),
        .timer_enable          (en),
        .timer_count           (cnt),
        .timer_interrupt_clear (clr),
        .timer_interrupt       (intr_b),
        .timer_expired         (exp_b),
        .timer_current         (cur_b),
        .timer_running         (run_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          run;
        bit          done;
        longint      n;      // value loaded at start of the current period
        longint      p;      // clocks elapsed in the current period
        logic [31:0] cur;
        bit          intr;
        bit          expd;
    } mdl_t;

    mdl_t m [2];
    int   div_of [2] = '{1, 4};

    function automatic void model_step(int i);
        longint k;
        m[i].expd = 1'b0;
        if (reset) begin
            m[i].run  = 1'b0;
            m[i].done = 1'b0;
            m[i].n    = 0;
            m[i].p    = 0;
            m[i].cur  = 32'd0;
            m[i].intr = 1'b0;
            return;
        end
        if (m[i].done) begin
            if (!en) m[i].done = 1'b0;
        end else if (!m[i].run) begin
            if (en) begin
                m[i].run = 1'b1;
                m[i].n   = longint'(cnt);
                m[i].p   = 0;
                m[i].cur = cnt;
            end
        end else if (!en) begin
            m[i].run = 1'b0;
        end else begin
            m[i].p = m[i].p + 1;
            if (m[i].p % div_of[i] == 0) begin
                k = m[i].p / div_of[i];
                if (k == m[i].n + 1) begin
                    m[i].expd = 1'b1;
`ifdef TIMER_COUNTER_ONESHOT_EN
                    m[i].run  = 1'b0;
                    m[i].done = 1'b1;
                    m[i].cur  = 32'd0;
`else
                    m[i].n    = longint'(cnt);
                    m[i].p    = 0;
                    m[i].cur  = cnt;
`endif
                end else begin
                    m[i].cur = 32'(m[i].n - k);
                end
            end
        end
        m[i].intr = clr ? 1'b0 : (m[i].intr | m[i].expd);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs as currently driven, model advanced, both DUTs compared.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("div1_current",   cur_a,  m[0].cur);
        check("div1_expired",   {31'd0, exp_a},  {31'd0, m[0].expd});
        check("div1_interrupt", {31'd0, intr_a}, {31'd0, m[0].intr});
        check("div1_running",   {31'd0, run_a},  {31'd0, m[0].run});
        check("div4_current",   cur_b,  m[1].cur);
        check("div4_expired",   {31'd0, exp_b},  {31'd0, m[1].expd});
        check("div4_interrupt", {31'd0, intr_b}, {31'd0, m[1].intr});
        check("div4_running",   {31'd0, run_b},  {31'd0, m[1].run});
    endtask

    task automatic drive(input logic r, input logic e, input logic [31:0] c, input logic cl);
        reset = r;
        en    = e;
        cnt   = c;
        clr   = cl;
    endtask

    // ---------------- directed table (PRESCALE_DIV=1 instance) ----------------
    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic [31:0] cnt;
        logic        intr;
        logic        expd;
        logic [31:0] cur;
        logic        run;
    } vec_t;

    vec_t tbl [24];

    initial begin
        int got;
        int period;

        foreach (m[i]) begin
            m[i].run = 1'b0; m[i].done = 1'b0; m[i].n = 0; m[i].p = 0;
            m[i].cur = 32'd0; m[i].intr = 1'b0; m[i].expd = 1'b0;
        end

        //            rst   en    clr   cnt            intr  exp   cur            run
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd0,          1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd0,          1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd3,          1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd2,          1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd1,          1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd0,          1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b1, 1'b1, 32'd3,          1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b1, 1'b0, 32'd2,          1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b1, 1'b0, 32'd1,          1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'd3,          1'b0, 1'b0, 32'd0,          1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'd3,          1'b0, 1'b1, 32'd3,          1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd2,          1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd1,          1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b0, 1'b0, 32'd0,          1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'd3,          1'b1, 1'b1, 32'd3,          1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'd3,          1'b1, 1'b0, 32'd3,          1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'd10,         1'b1, 1'b0, 32'd3,          1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 1'b0, 32'd0,          1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 1'b1, 32'd0,          1'b1};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 32'd0,          1'b1, 1'b1, 32'd0,          1'b1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 32'd0,          1'b0};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'hFFFF_FFFF,  1'b1};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'hFFFF_FFFE,  1'b1};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'hFFFF_FFFE,  1'b0};

        @(negedge clk);

`ifndef TIMER_COUNTER_ONESHOT_EN
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].cnt, tbl[i].clr);
            step();
            check($sformatf("tbl%0d_current", i),   cur_a, tbl[i].cur);
            check($sformatf("tbl%0d_expired", i),   {31'd0, exp_a},  {31'd0, tbl[i].expd});
            check($sformatf("tbl%0d_interrupt", i), {31'd0, intr_a}, {31'd0, tbl[i].intr});
            check($sformatf("tbl%0d_running", i),   {31'd0, run_a},  {31'd0, tbl[i].run});
        end

        // Prescale: DIV=4, N=1 -> expiry 8 clocks after load, then every 8.
        drive(1'b1, 1'b0, 32'd1, 1'b0); step();
        drive(1'b0, 1'b1, 32'd1, 1'b0); step();   // load
        for (int rep = 0; rep < 2; rep++) begin
            got = -1;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (exp_b) begin got = c; break; end
            end
            check($sformatf("prescale_period%0d", rep), got, 8);
        end

        // Disable mid-count on DIV=1: N=10, drop enable at 6, re-enable reloads.
        drive(1'b1, 1'b0, 32'd10, 1'b0); step();
        drive(1'b0, 1'b1, 32'd10, 1'b0);
        got = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (cur_a == 32'd6) begin got = c; break; end
        end
        check("disable_reach6_clocks", got, 5);
        drive(1'b0, 1'b0, 32'd10, 1'b0); step();
        check("disable_frozen",  cur_a, 32'd6);
        check("disable_idle",    {31'd0, run_a}, 32'd0);
        step(); step();
        check("disable_hold",    cur_a, 32'd6);
        drive(1'b0, 1'b1, 32'd10, 1'b0); step();
        check("reenable_reload", cur_a, 32'd10);
        check("reenable_run",    {31'd0, run_a}, 32'd1);
`else
        // One-shot, DIV=1, N=2: one expiry after 3 ticks, then parked in DONE.
        drive(1'b1, 1'b1, 32'd2, 1'b0); step(); step();
        drive(1'b0, 1'b1, 32'd2, 1'b0); step();   // load
        check("oneshot_load", cur_a, 32'd2);
        got = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (exp_a) begin got = c; break; end
        end
        check("oneshot_ticks_to_expiry", got, 3);
        check("oneshot_interrupt", {31'd0, intr_a}, 32'd1);
        period = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (exp_a) period++;
        end
        check("oneshot_no_repeat", period, 0);
        check("oneshot_done_current", cur_a, 32'd0);
        check("oneshot_done_running", {31'd0, run_a}, 32'd0);
        drive(1'b0, 1'b0, 32'd2, 1'b0); step();
        drive(1'b0, 1'b1, 32'd2, 1'b0); step();
        check("oneshot_rearm_current", cur_a, 32'd2);
        check("oneshot_rearm_running", {31'd0, run_a}, 32'd1);
`endif

        // Randomized run against the model, small reload values so many
        // expiries, clears and disables land on ticks.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 6)),
                  ($urandom_range(0, 9) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
